// File: rtl/dm_pkg.sv
// Shared encodings and lane helpers for the data-memory bank wrapper.
package dm_pkg;

  typedef enum logic [1:0] {
    DOPC_WORD  = 2'b00,
    DOPC_HALF  = 2'b01,
    DOPC_BYTE  = 2'b10,
    DOPC_FWORD = 2'b11
  } dopc_e;

  typedef enum logic [1:0] {
    NORMAL = 2'd0,
    DRAIN  = 2'd1,
    BIST   = 2'd2
  } dm_state_e;

  // Active-high lane mask for an access of the given size starting at lane off.
  // Sized for up to 8 lanes; callers truncate to their own lane count.
  function automatic logic [7:0] lane_mask(input dopc_e dopc, input logic [2:0] off,
                                           input int unsigned lanes);
    logic [7:0] m;
    unique case (dopc)
      DOPC_BYTE: m = 8'h01;
      DOPC_HALF: m = 8'h03;
      default:   m = 8'hFF >> (8 - lanes);
    endcase
    return m << off;
  endfunction

  // Replicates byte or half store data across every lane of a 64-bit bus.
  function automatic logic [63:0] lane_rep(input dopc_e dopc, input logic [63:0] d);
    logic [63:0] r;
    unique case (dopc)
      DOPC_BYTE: r = {8{d[7:0]}};
      DOPC_HALF: r = {4{d[15:0]}};
      default:   r = d;
    endcase
    return r;
  endfunction

  // Half must be even-aligned, word must sit at lane 0; bytes are always aligned.
  function automatic logic is_misaligned(input dopc_e dopc, input logic [2:0] off);
    logic m;
    unique case (dopc)
      DOPC_BYTE: m = 1'b0;
      DOPC_HALF: m = off[0];
      default:   m = (off != 3'd0);
    endcase
    return m;
  endfunction

endpackage

// File: rtl/dm_load_align.sv
// Load-data alignment: shifts the addressed lanes down and zero/sign-extends.
module dm_load_align
  import dm_pkg::*;
#(
  parameter  int unsigned DATA_W = 32,
  localparam int unsigned OFF_W  = $clog2(DATA_W / 8)
) (
  input  logic [DATA_W-1:0] word,
  input  logic [OFF_W-1:0]  off,
  input  dopc_e             dopc,
  input  logic              sign_ext,
  output logic [DATA_W-1:0] data
);

  logic [DATA_W-1:0] shifted;

  // Extract the addressed bytes and extend them to the full data width.
  always_comb begin
    shifted = word >> {off, 3'b000};
    data    = shifted;
    unique case (dopc)
      DOPC_HALF: data = {{(DATA_W-16){sign_ext & shifted[15]}}, shifted[15:0]};
      DOPC_BYTE: data = {{(DATA_W-8){sign_ext & shifted[7]}}, shifted[7:0]};
      default:   data = shifted;
    endcase
  end

endmodule

// File: rtl/dm_bank_wrapper.sv
// Data-memory wrapper: Mem-stage decode onto NBANKS SRAM banks, registered
// load alignment, and BIST ownership arbitration with a one-cycle drain.
module dm_bank_wrapper
  import dm_pkg::*;
#(
  parameter  int unsigned ADDR_W  = 16,
  parameter  int unsigned DATA_W  = 32,
  parameter  int unsigned NBANKS  = 4,
  localparam int unsigned LANES   = DATA_W / 8,
  localparam int unsigned OFF_W   = $clog2(LANES),
  localparam int unsigned SEL_W   = $clog2(NBANKS),
  localparam int unsigned BANK_AW = ADDR_W - OFF_W - SEL_W
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      req_i,
  input  logic [ADDR_W-1:0]         addr_i,
  input  logic [DATA_W-1:0]         data_i,
  input  logic                      mem_wen_i,
  input  logic [1:0]                dm_dopc_i,
  input  logic                      sign_i,
  input  logic                      bist_req_i,
  output logic                      bist_ack_o,
  input  logic [SEL_W+BANK_AW-1:0]  bist_addr_i,
  input  logic [DATA_W-1:0]         bist_data_i,
  input  logic                      bist_wen_i,
  input  logic [NBANKS*DATA_W-1:0]  q_bank_i,
  output logic [BANK_AW-1:0]        mem_addr_o,
  output logic [NBANKS-1:0]         mem_ce_n_o,
  output logic [NBANKS*LANES-1:0]   mem_wen_n_o,
  output logic [DATA_W-1:0]         mem_d_o,
  output logic [DATA_W-1:0]         q_o,
  output logic                      q_valid_o,
  output logic                      misalign_o
);

  dm_state_e state, state_n;

  // Functional access decode
  dopc_e              f_dopc;
  logic [SEL_W-1:0]   f_bank;
  logic [BANK_AW-1:0] f_word;
  logic [OFF_W-1:0]   f_off;
  logic [2:0]         f_off3;
  logic [63:0]        f_d64;
  logic [LANES-1:0]   f_mask;
  logic [DATA_W-1:0]  f_wdata;
  logic               f_store, f_mis, f_go;

  // BIST access decode
  logic [SEL_W-1:0]   b_bank;
  logic [BANK_AW-1:0] b_word;

  // Read issue this cycle and its latched copy
  logic               rd_issue;
  logic [SEL_W-1:0]   rd_bank;
  logic [OFF_W-1:0]   rd_off;
  dopc_e              rd_dopc;
  logic               rd_sign;

  logic               rd_v_q;
  logic [SEL_W-1:0]   rd_bank_q;
  logic [OFF_W-1:0]   rd_off_q;
  dopc_e              rd_dopc_q;
  logic               rd_sign_q;
  logic               mis_q;
  logic               ack_q;

  logic [DATA_W-1:0]  aligned;

  assign f_dopc  = dopc_e'(dm_dopc_i);
  assign f_bank  = addr_i[ADDR_W-1 -: SEL_W];
  assign f_word  = addr_i[OFF_W +: BANK_AW];
  assign f_off   = addr_i[OFF_W-1:0];
  assign f_off3  = 3'(f_off);
  assign f_d64   = 64'(data_i);
  assign f_mask  = LANES'(lane_mask(f_dopc, f_off3, LANES));
  assign f_wdata = DATA_W'(lane_rep(f_dopc, f_d64));
  assign f_store = mem_wen_i | (f_dopc == DOPC_FWORD);
  assign f_mis   = is_misaligned(f_dopc, f_off3);
  assign f_go    = (state == NORMAL) & req_i & ~f_mis;

  assign b_bank  = bist_addr_i[SEL_W+BANK_AW-1 -: SEL_W];
  assign b_word  = bist_addr_i[BANK_AW-1:0];

  // Ownership FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= NORMAL;
    else      state <= state_n;
  end

  // Ownership next-state: one drain cycle lets the last functional read return
  always_comb begin
    state_n = state;
    unique case (state)
      NORMAL:  if (bist_req_i) state_n = DRAIN;
      DRAIN:   state_n = bist_req_i ? BIST : NORMAL;
      BIST:    if (!bist_req_i) state_n = NORMAL;
      default: state_n = NORMAL;
    endcase
  end

  // Bank macro drive and read-issue decode for the current owner
  always_comb begin
    mem_ce_n_o  = '1;
    mem_wen_n_o = '1;
    mem_addr_o  = f_word;
    mem_d_o     = f_wdata;
    rd_issue    = 1'b0;
    rd_bank     = f_bank;
    rd_off      = f_off;
    rd_dopc     = f_dopc;
    rd_sign     = sign_i;
    if (state == BIST) begin
      mem_ce_n_o[b_bank]                    = 1'b0;
      mem_wen_n_o[b_bank*LANES +: LANES]    = {LANES{bist_wen_i}};
      mem_addr_o                            = b_word;
      mem_d_o                               = bist_data_i;
      rd_issue                              = bist_wen_i;
      rd_bank                               = b_bank;
      rd_off                                = '0;
      rd_dopc                               = DOPC_WORD;
      rd_sign                               = 1'b0;
    end else if (f_go) begin
      mem_ce_n_o[f_bank] = 1'b0;
      if (f_store) mem_wen_n_o[f_bank*LANES +: LANES] = ~f_mask;
      else         rd_issue = 1'b1;
    end
  end

  // Read pipeline, misalign pulse and registered acknowledge
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_v_q    <= 1'b0;
      rd_bank_q <= '0;
      rd_off_q  <= '0;
      rd_dopc_q <= DOPC_WORD;
      rd_sign_q <= 1'b0;
      mis_q     <= 1'b0;
      ack_q     <= 1'b0;
    end else begin
      rd_v_q <= rd_issue;
      if (rd_issue) begin
        rd_bank_q <= rd_bank;
        rd_off_q  <= rd_off;
        rd_dopc_q <= rd_dopc;
        rd_sign_q <= rd_sign;
      end
      mis_q <= (state == NORMAL) & req_i & f_mis;
      ack_q <= (state_n == BIST);
    end
  end

  dm_load_align #(
    .DATA_W(DATA_W)
  ) u_align (
    .word     (q_bank_i[rd_bank_q*DATA_W +: DATA_W]),
    .off      (rd_off_q),
    .dopc     (rd_dopc_q),
    .sign_ext (rd_sign_q),
    .data     (aligned)
  );

  assign q_o        = rd_v_q ? aligned : '0;
  assign q_valid_o  = rd_v_q;
  assign misalign_o = mis_q;
  assign bist_ack_o = ack_q;

endmodule

// File: tb/tb_dm_bank_wrapper.sv
// Bench for dm_bank_wrapper: SRAM bank models, a byte-addressed reference
// memory with an ownership-phase model, and directed plus random stimulus.
module tb_dm_bank_wrapper;

  localparam int ADDR_W  = 16;
  localparam int DATA_W  = 32;
  localparam int NBANKS  = 4;
  localparam int LANES   = 4;
  localparam int BANK_AW = 12;

  localparam int P_CORE  = 0;
  localparam int P_DRAIN = 1;
  localparam int P_BIST  = 2;

  logic                     clk = 1'b0;
  logic                     rst = 1'b0;
  logic                     req_i = 1'b0;
  logic [ADDR_W-1:0]        addr_i = '0;
  logic [DATA_W-1:0]        data_i = '0;
  logic                     mem_wen_i = 1'b0;
  logic [1:0]               dm_dopc_i = 2'b00;
  logic                     sign_i = 1'b0;
  logic                     bist_req_i = 1'b0;
  logic                     bist_ack_o;
  logic [13:0]              bist_addr_i = '0;
  logic [DATA_W-1:0]        bist_data_i = '0;
  logic                     bist_wen_i = 1'b1;
  logic [NBANKS*DATA_W-1:0] q_bank_i;
  logic [BANK_AW-1:0]       mem_addr_o;
  logic [NBANKS-1:0]        mem_ce_n_o;
  logic [NBANKS*LANES-1:0]  mem_wen_n_o;
  logic [DATA_W-1:0]        mem_d_o;
  logic [DATA_W-1:0]        q_o;
  logic                     q_valid_o;
  logic                     misalign_o;

  dm_bank_wrapper #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .NBANKS(NBANKS)) dut (
    .clk(clk), .rst(rst), .req_i(req_i), .addr_i(addr_i), .data_i(data_i),
    .mem_wen_i(mem_wen_i), .dm_dopc_i(dm_dopc_i), .sign_i(sign_i),
    .bist_req_i(bist_req_i), .bist_ack_o(bist_ack_o), .bist_addr_i(bist_addr_i),
    .bist_data_i(bist_data_i), .bist_wen_i(bist_wen_i), .q_bank_i(q_bank_i),
    .mem_addr_o(mem_addr_o), .mem_ce_n_o(mem_ce_n_o), .mem_wen_n_o(mem_wen_n_o),
    .mem_d_o(mem_d_o), .q_o(q_o), .q_valid_o(q_valid_o), .misalign_o(misalign_o)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- SRAM bank macros (environment) ----------------
  logic [31:0] sram   [NBANKS][4096];
  logic [31:0] sram_q [NBANKS];

  initial begin
    for (int b = 0; b < NBANKS; b++) begin
      sram_q[b] = '0;
      for (int w = 0; w < 4096; w++) sram[b][w] = '0;
    end
  end

  always @(posedge clk) begin
    for (int b = 0; b < NBANKS; b++) begin
      if (!mem_ce_n_o[b]) begin
        if (&mem_wen_n_o[b*4 +: 4]) begin
          sram_q[b] <= sram[b][mem_addr_o];
        end else begin
          logic [31:0] w;
          w = sram[b][mem_addr_o];
          for (int l = 0; l < 4; l++)
            if (!mem_wen_n_o[b*4+l]) w[l*8 +: 8] = mem_d_o[l*8 +: 8];
          sram[b][mem_addr_o] <= w;
        end
      end
    end
  end

  always_comb begin
    q_bank_i = '0;
    for (int b = 0; b < NBANKS; b++) q_bank_i[b*32 +: 32] = sram_q[b];
  end

  // ---------------- Reference model ----------------
  logic [7:0]  shadow [65536];
  int          phase = P_CORE;
  logic        e_ack = 1'b0, e_qv = 1'b0, e_mis = 1'b0;
  logic [31:0] e_q = '0;

  initial for (int a = 0; a < 65536; a++) shadow[a] = 8'h00;

  // Inputs are stable at the falling edge: check last edge's results and
  // this cycle's bank drive, then advance the model across the next edge.
  always @(negedge clk) begin : compare
    logic [3:0]  ce_x;
    logic [15:0] wen_x;
    logic [31:0] d_x, nq;
    logic        nqv, nmis;
    int          n, off, bank, base;
    if (!rst) begin
      phase = P_CORE;
      e_ack = 1'b0; e_qv = 1'b0; e_q = '0; e_mis = 1'b0;
      check("rst_ack", bist_ack_o, 0);
      check("rst_q_valid", q_valid_o, 0);
      check("rst_misalign", misalign_o, 0);
      check("rst_ce_n", mem_ce_n_o, 64'hF);
      check("rst_wen_n", mem_wen_n_o, 64'hFFFF);
    end else begin
      check("ack", bist_ack_o, e_ack);
      check("q_valid", q_valid_o, e_qv);
      check("q", q_o, e_q);
      check("misalign", misalign_o, e_mis);
      ce_x = '1; wen_x = '1; nq = '0; nqv = 1'b0; nmis = 1'b0;
      if (phase == P_BIST) begin
        bank = int'(bist_addr_i) / 4096;
        base = int'(bist_addr_i) * 4;
        ce_x[bank] = 1'b0;
        wen_x[bank*4 +: 4] = {4{bist_wen_i}};
        check("bist_addr", mem_addr_o, int'(bist_addr_i) % 4096);
        check("bist_d", mem_d_o, bist_data_i);
        if (!bist_wen_i) begin
          for (int k = 0; k < 4; k++) shadow[base+k] = bist_data_i[8*k +: 8];
        end else begin
          nqv = 1'b1;
          for (int k = 0; k < 4; k++) nq[8*k +: 8] = shadow[base+k];
        end
      end else if (phase == P_CORE && req_i) begin
        n   = (dm_dopc_i == 2'b01) ? 2 : (dm_dopc_i == 2'b10) ? 1 : 4;
        off = int'(addr_i) % 4;
        if (off % n != 0) begin
          nmis = 1'b1;
        end else begin
          bank = int'(addr_i) / 16384;
          ce_x[bank] = 1'b0;
          check("addr", mem_addr_o, (int'(addr_i) / 4) % 4096);
          if (mem_wen_i || dm_dopc_i == 2'b11) begin
            for (int l = 0; l < 4; l++) begin
              if (l >= off && l < off + n) wen_x[bank*4+l] = 1'b0;
              d_x[8*l +: 8] = data_i[8*(l%n) +: 8];
            end
            check("store_d", mem_d_o, d_x);
            for (int k = 0; k < n; k++) shadow[int'(addr_i)+k] = data_i[8*k +: 8];
          end else begin
            nqv = 1'b1;
            for (int k = 0; k < n; k++) nq[8*k +: 8] = shadow[int'(addr_i)+k];
            if (sign_i && n < 4 && nq[8*n-1])
              for (int k = n; k < 4; k++) nq[8*k +: 8] = 8'hFF;
          end
        end
      end
      check("ce_n", mem_ce_n_o, ce_x);
      check("wen_n", mem_wen_n_o, wen_x);
      case (phase)
        P_CORE:  if (bist_req_i) phase = P_DRAIN;
        P_DRAIN: phase = bist_req_i ? P_BIST : P_CORE;
        default: if (!bist_req_i) phase = P_CORE;
      endcase
      e_ack = (phase == P_BIST);
      e_qv  = nqv;
      e_q   = nq;
      e_mis = nmis;
    end
  end

  // ---------------- Stimulus ----------------
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic idle();
    req_i = 1'b0; mem_wen_i = 1'b0; dm_dopc_i = 2'b00; sign_i = 1'b0;
    addr_i = '0; data_i = '0;
  endtask

  task automatic access(input logic [15:0] a, input logic [1:0] dopc, input logic st,
                        input logic sg, input logic [31:0] d);
    req_i = 1'b1; addr_i = a; dm_dopc_i = dopc; mem_wen_i = st; sign_i = sg; data_i = d;
  endtask

  initial begin
    // 1: reset then release with no request
    repeat (3) cyc();
    rst = 1'b1;
    #1;
    check("t1_ce_n", mem_ce_n_o, 64'hF);
    check("t1_wen_n", mem_wen_n_o, 64'hFFFF);
    check("t1_ack", bist_ack_o, 0);
    check("t1_q_valid", q_valid_o, 0);

    // 2: byte store 0xA5 at 0x4003, signed byte load back
    cyc(); access(16'h4003, 2'b10, 1'b1, 1'b0, 32'h0000_00A5);
    #1;
    check("t2_st_ce_n", mem_ce_n_o, 64'b1101);
    check("t2_st_wen_n", mem_wen_n_o, 64'hFF7F);
    check("t2_st_d", mem_d_o, 64'hA5A5_A5A5);
    cyc(); access(16'h4003, 2'b10, 1'b0, 1'b1, 32'h0);
    #1;
    check("t2_ld_ce_n", mem_ce_n_o, 64'b1101);
    check("t2_ld_wen_n", mem_wen_n_o, 64'hFFFF);
    cyc(); idle();
    #1;
    check("t2_q_valid", q_valid_o, 1);
    check("t2_q", q_o, 64'hFFFF_FFA5);

    // 3: misaligned half load
    cyc(); access(16'h0001, 2'b01, 1'b0, 1'b0, 32'h0);
    #1;
    check("t3_ce_n", mem_ce_n_o, 64'hF);
    cyc(); idle();
    #1;
    check("t3_misalign", misalign_o, 1);
    check("t3_q_valid", q_valid_o, 0);
    cyc();
    #1;
    check("t3_misalign_pulse", misalign_o, 0);

    // 4: load in the same cycle BIST asks for the banks
    cyc(); access(16'h4000, 2'b00, 1'b0, 1'b0, 32'h0); bist_req_i = 1'b1;
    #1;
    check("t4_ld_ce_n", mem_ce_n_o, 64'b1101);
    cyc(); access(16'h8000, 2'b00, 1'b1, 1'b0, 32'hDEAD_BEEF);
    #1;
    check("t4_drain_q_valid", q_valid_o, 1);
    check("t4_drain_q", q_o, 64'hA500_0000);
    check("t4_drain_ce_n", mem_ce_n_o, 64'hF);
    check("t4_drain_ack", bist_ack_o, 0);
    cyc(); idle(); bist_wen_i = 1'b1; bist_addr_i = 14'h0000;
    #1;
    check("t4_ack", bist_ack_o, 1);

    // 5: BIST write then read at the top word of bank 3
    cyc(); bist_addr_i = 14'h3FFF; bist_data_i = 32'h5A5A_5A5A; bist_wen_i = 1'b0;
    #1;
    check("t5_wr_ce_n", mem_ce_n_o, 64'b0111);
    check("t5_wr_wen_n", mem_wen_n_o, 64'h0FFF);
    check("t5_wr_addr", mem_addr_o, 64'hFFF);
    cyc(); bist_wen_i = 1'b1; bist_data_i = '0;
    #1;
    check("t5_rd_ce_n", mem_ce_n_o, 64'b0111);
    check("t5_rd_wen_n", mem_wen_n_o, 64'hFFFF);
    cyc();
    #1;
    check("t5_q_valid", q_valid_o, 1);
    check("t5_q", q_o, 64'h5A5A_5A5A);

    // 6: asynchronous reset while BIST owns the banks
    cyc(); rst = 1'b0;
    #1;
    check("t6_ack", bist_ack_o, 0);
    check("t6_wen_n", mem_wen_n_o, 64'hFFFF);
    check("t6_ce_n", mem_ce_n_o, 64'hF);
    check("t6_q_valid", q_valid_o, 0);
    bist_req_i = 1'b0;
    cyc(); rst = 1'b1;

    // Random traffic over a few words per bank so loads hit earlier stores
    for (int i = 0; i < 3000; i++) begin
      cyc();
      req_i     = ($urandom % 4) != 0;
      addr_i    = 16'((($urandom % 4) << 14) | (($urandom % 8) << 2) |
                      ((($urandom % 3) == 0) ? ($urandom % 4) : 0));
      dm_dopc_i = 2'($urandom % 4);
      mem_wen_i = 1'($urandom % 2);
      sign_i    = 1'($urandom % 2);
      data_i    = $urandom;
      if (($urandom % 24) == 0) bist_req_i = ~bist_req_i;
      bist_addr_i = 14'((($urandom % 4) << 12) | ($urandom % 8));
      bist_wen_i  = 1'($urandom % 2);
      bist_data_i = $urandom;
    end

    cyc(); idle(); bist_req_i = 1'b0; bist_wen_i = 1'b1;
    repeat (4) cyc();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
